// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg / wb_arbiter_if
//   Shared writeback payload type and the bus bundle between the execution
//   pipelines, the writeback merge stage and the reorder buffer write port.
//
//   Signals in the bundle:
//     req_valid     per-source writeback request valid (producer -> merge)
//     req_info      per-source writeback payload       (producer -> merge)
//     stall_src     per-source early stall             (merge -> producer)
//     rob_ready     RoB accepts the presented request  (RoB -> merge)
//     req_rob_valid registered request valid           (merge -> RoB)
//     req_rob_info  registered request payload         (merge -> RoB)
//     overflow_err  sticky dropped-push indicator      (merge -> system)
//
//   Modports: slave is the merge stage, master is its environment.
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

  typedef struct packed {
    logic [5:0]  instr_id;
    logic [31:0] data;
    logic        exc;
  } writeback_request_t;

endpackage

interface wb_arbiter_if #(
  parameter int NUM_SRC = 3
);
  import wb_arbiter_pkg::*;

  logic [NUM_SRC-1:0] req_valid;
  writeback_request_t req_info [NUM_SRC];
  logic [NUM_SRC-1:0] stall_src;
  logic               rob_ready;
  logic               req_rob_valid;
  writeback_request_t req_rob_info;
  logic               overflow_err;

  modport master (
    output req_valid, req_info, rob_ready,
    input  stall_src, req_rob_valid, req_rob_info, overflow_err
  );

  modport slave (
    input  req_valid, req_info, rob_ready,
    output stall_src, req_rob_valid, req_rob_info, overflow_err
  );

endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Writeback merge stage between the ALU/MUL/CACHE pipelines and the RoB
//   write port. Each source owns a small FIFO; a round-robin arbiter pops one
//   FIFO head per cycle into a registered output toward the RoB. Producers
//   have no ready input, so each gets an early stall derived from occupancy.
//
//   Ports:
//     clock     rising-edge clock
//     reset     asynchronous, active-low reset
//     flush_wb  synchronous flush of all queued and presented requests
//     bus       wb_arbiter_if.slave (requests in, stalls out, RoB request out)
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_THRESH = 2
) (
  input logic        clock,
  input logic        reset,
  input logic        flush_wb,
  wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - STALL_THRESH);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);

  writeback_request_t mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
  logic [CNT_W-1:0]   count  [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;

  logic               out_free;
  logic               found;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   search_idx;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] push_ok;
  logic [NUM_SRC-1:0] push_drop;

  // Stall is purely occupancy based so producers see it one cycle early
  // enough to cover requests already in flight in their pipelines.
  always_comb begin
    bus.stall_src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.stall_src[i] = (count[i] >= STALL_CNT);
    end
  end

  // Round-robin search: walk the sources starting at rr_ptr, wrapping, and
  // take the first one with a non-empty FIFO.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    search_idx = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && (count[search_idx] != '0)) begin
        found  = 1'b1;
        winner = search_idx;
      end
      search_idx = (search_idx == LAST_SRC) ? '0 : search_idx + 1'b1;
    end
  end

  // A pop only happens when the output register can take a new entry.
  // A push into a full FIFO is still accepted if that same FIFO is being
  // popped this cycle; otherwise it is dropped and flagged. Flush drops
  // every push of its cycle without flagging it.
  always_comb begin
    out_free  = !bus.req_rob_valid || bus.rob_ready;
    pop       = '0;
    push_ok   = '0;
    push_drop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]       = out_free && found && !flush_wb && (winner == SRC_W'(i));
      push_ok[i]   = bus.req_valid[i] && !flush_wb &&
                     ((count[i] != FULL_CNT) || pop[i]);
      push_drop[i] = bus.req_valid[i] && !flush_wb &&
                     (count[i] == FULL_CNT) && !pop[i];
    end
  end

  // FIFO storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_ok[i]) begin
        mem[i][wr_ptr[i]] <= bus.req_info[i];
      end
    end
  end

  // Pointers, counts, round-robin pointer and the RoB output register.
  // overflow_err survives flush on purpose so a lost writeback stays visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr            <= '0;
      bus.req_rob_valid <= 1'b0;
      bus.req_rob_info  <= '0;
      bus.overflow_err  <= 1'b0;
    end else begin
      if (|push_drop) begin
        bus.overflow_err <= 1'b1;
      end
      if (flush_wb) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end
        rr_ptr            <= '0;
        bus.req_rob_valid <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (push_ok[i]) begin
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
          end
          if (pop[i]) begin
            rd_ptr[i] <= rd_ptr[i] + 1'b1;
          end
          case ({push_ok[i], pop[i]})
            2'b10:   count[i] <= count[i] + 1'b1;
            2'b01:   count[i] <= count[i] - 1'b1;
            default: count[i] <= count[i];
          endcase
        end
        if (out_free) begin
          if (found) begin
            bus.req_rob_valid <= 1'b1;
            bus.req_rob_info  <= mem[winner][rd_ptr[winner]];
            rr_ptr            <= (winner == LAST_SRC) ? '0 : winner + 1'b1;
          end else begin
            bus.req_rob_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule
